m1_rgb_writer: RTL

Colour-space conversion and SRAM write-back stage at the tail of the decoder. It accepts an upsampled YUV pixel stream and converts each pixel to clipped 8-bit RGB through a 3-stage pipeline. It packs pixel pairs into 16-bit words and writes them sequentially into the RGB region of external SRAM, which is the region the VGA path reads and the project bench checks.

---
 rtl/m1_pkg.sv | 42 ++++
 rtl/m1_rgb_fifo.sv | 49 ++++
 rtl/m1_rgb_writer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/m1_pkg.sv
// Shared types and constants for the RGB write-back stage: writer states,
// colour-conversion coefficients, SRAM base address and the packed pixel type.
package m1_pkg;

   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned FIFO_CNT_W = 4;
   localparam logic [17:0] RGB_BASE_DEF = 18'd146944;

   localparam int COEF_A = 76284;
   localparam int COEF_B = 104595;
   localparam int COEF_C = 25624;
   localparam int COEF_D = 53281;
   localparam int COEF_E = 132251;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_W0,
      S_W1,
      S_W2,
      S_DONE
   } wr_state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Drop the 16 fractional bits of a fixed-point sum and saturate to 0..255.
   function automatic logic [7:0] clip8(input logic signed [31:0] sum);
      logic signed [31:0] sh;
      sh = sum >>> 16;
      if (sh < 0)
         return 8'd0;
      else if (sh > 255)
         return 8'd255;
      else
         return sh[7:0];
   endfunction

endpackage

// File: rtl/m1_rgb_fifo.sv
// 8-entry x 24-bit pixel FIFO; exposes the two oldest entries and pops 1 or 2 per cycle.
module m1_rgb_fifo
   import m1_pkg::*;
(
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic                  i_push,
   input  logic [23:0]           i_push_data,
   input  logic                  i_pop,
   input  logic                  i_pop_two,
   output logic [23:0]           o_head0_c,
   output logic [23:0]           o_head1_c,
   output logic [FIFO_CNT_W-1:0] o_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [23:0]           r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [FIFO_CNT_W-1:0] r_count;
   logic [FIFO_CNT_W-1:0] w_pop_n;

   assign w_pop_n = i_pop ? (i_pop_two ? FIFO_CNT_W'(2) : FIFO_CNT_W'(1)) : '0;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
         r_count  <= r_count + FIFO_CNT_W'(i_push) - w_pop_n;
      end
   end

   // Storage needs no reset: entries are only read once the count covers them.
   always_ff @(posedge Clock) begin
      if (i_push)
         r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_head0_c = r_mem[r_rd_ptr];
   assign o_head1_c = r_mem[r_rd_ptr + PTR_W'(1)];
   assign o_count   = r_count;

endmodule

// File: rtl/m1_rgb_writer.sv
// YUV->RGB conversion (3-stage pipeline) feeding a pixel FIFO, and a writer FSM
// that packs pixel pairs into three 16-bit words written sequentially to SRAM.
module m1_rgb_writer
   import m1_pkg::*;
#(
   parameter int unsigned NUM_PIXELS = 76800,
   parameter logic [17:0] RGB_BASE   = RGB_BASE_DEF
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  Y_in,
   input  logic [7:0]  U_in,
   input  logic [7:0]  V_in,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        busy,
   output logic        done
);

   localparam int unsigned PIX_W  = $clog2(NUM_PIXELS + 1);
   localparam int unsigned PAIRS  = NUM_PIXELS / 2;
   localparam int unsigned PAIR_W = $clog2(PAIRS + 1);
   localparam logic [PIX_W-1:0]  NUM_PIX_L = PIX_W'(NUM_PIXELS);
   localparam logic [PAIR_W-1:0] PAIRS_L   = PAIR_W'(PAIRS);

   wr_state_t r_state, w_state_nx;
   logic [17:0]       r_addr, w_addr_nx;
   logic [15:0]       r_data, w_data_nx;
   logic              r_we_n, w_we_n_nx;
   logic              r_busy, w_busy_nx;
   logic              r_done, w_done_nx;
   logic              r_in_ready, w_in_ready_nx;
   logic [PIX_W-1:0]  r_acc_cnt, w_acc_nx;
   logic [PAIR_W-1:0] r_pair_cnt, w_pair_nx;

   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   rgb_t                  w_rgb;
   rgb_t                  w_h0, w_h1;
   logic [23:0]           w_head0_raw, w_head1_raw;
   logic [FIFO_CNT_W-1:0] w_fifo_cnt;
   logic [FIFO_CNT_W-1:0] w_fifo_cnt_nx;
   logic [FIFO_CNT_W-1:0] w_infl_nx;
   logic [FIFO_CNT_W-1:0] w_credit_nx;

   logic              r_p1_valid, r_p2_valid;
   logic signed [8:0] r_y, r_u, r_v;
   logic signed [31:0] r_ay, r_bv, r_cu, r_dv, r_eu;
   logic signed [31:0] w_sum_r, w_sum_g, w_sum_b;

   assign w_accept = in_valid && r_in_ready;
   assign w_push   = r_p2_valid;

   // P1 removes offsets, P2 multiplies; P3 is the sum/clip feeding the FIFO write.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_p1_valid <= 1'b0;
         r_p2_valid <= 1'b0;
         r_y  <= '0;
         r_u  <= '0;
         r_v  <= '0;
         r_ay <= '0;
         r_bv <= '0;
         r_cu <= '0;
         r_dv <= '0;
         r_eu <= '0;
      end else begin
         r_p1_valid <= w_accept;
         r_p2_valid <= r_p1_valid;
         if (w_accept) begin
            r_y <= $signed({1'b0, Y_in}) - 9'sd16;
            r_u <= $signed({1'b0, U_in}) - 9'sd128;
            r_v <= $signed({1'b0, V_in}) - 9'sd128;
         end
         if (r_p1_valid) begin
            r_ay <= COEF_A * 32'(r_y);
            r_bv <= COEF_B * 32'(r_v);
            r_cu <= COEF_C * 32'(r_u);
            r_dv <= COEF_D * 32'(r_v);
            r_eu <= COEF_E * 32'(r_u);
         end
      end
   end

   always_comb begin
      w_sum_r = r_ay + r_bv;
      w_sum_g = r_ay - r_cu - r_dv;
      w_sum_b = r_ay + r_eu;
      w_rgb.r = clip8(w_sum_r);
      w_rgb.g = clip8(w_sum_g);
      w_rgb.b = clip8(w_sum_b);
   end

   m1_rgb_fifo u_fifo (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .i_push      (w_push),
      .i_push_data (w_rgb),
      .i_pop       (w_pop),
      .i_pop_two   (1'b1),
      .o_head0_c   (w_head0_raw),
      .o_head1_c   (w_head1_raw),
      .o_count     (w_fifo_cnt)
   );

   assign w_h0 = w_head0_raw;
   assign w_h1 = w_head1_raw;

   always_comb begin
      w_state_nx = r_state;
      w_we_n_nx  = 1'b1;
      w_data_nx  = r_data;
      w_addr_nx  = r_addr;
      w_busy_nx  = r_busy;
      w_done_nx  = 1'b0;
      w_pop      = 1'b0;
      w_pair_nx  = r_pair_cnt;
      w_acc_nx   = r_acc_cnt + PIX_W'(w_accept);

      // Step past each presented word; the final word's address is left in place.
      if (!r_we_n && (r_state != S_DONE))
         w_addr_nx = r_addr + 18'd1;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nx = S_WAIT;
               w_busy_nx  = 1'b1;
               w_addr_nx  = RGB_BASE;
               w_acc_nx   = '0;
               w_pair_nx  = '0;
            end
         end
         S_WAIT: begin
            if (w_fifo_cnt >= FIFO_CNT_W'(2))
               w_state_nx = S_W0;
         end
         S_W0: begin
            w_we_n_nx  = 1'b0;
            w_data_nx  = {w_h0.r, w_h0.g};
            w_state_nx = S_W1;
         end
         S_W1: begin
            w_we_n_nx  = 1'b0;
            w_data_nx  = {w_h0.b, w_h1.r};
            w_state_nx = S_W2;
         end
         S_W2: begin
            w_we_n_nx = 1'b0;
            w_data_nx = {w_h1.g, w_h1.b};
            w_pop     = 1'b1;
            w_pair_nx = r_pair_cnt + PAIR_W'(1);
            if (w_pair_nx == PAIRS_L)
               w_state_nx = S_DONE;
            else if (w_fifo_cnt >= FIFO_CNT_W'(4))
               w_state_nx = S_W0;
            else
               w_state_nx = S_WAIT;
         end
         S_DONE: begin
            w_done_nx  = 1'b1;
            w_busy_nx  = 1'b0;
            w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase

      // in_ready is registered, so its credit test uses next-cycle occupancy.
      w_fifo_cnt_nx = w_fifo_cnt + FIFO_CNT_W'(w_push) - (w_pop ? FIFO_CNT_W'(2) : '0);
      w_infl_nx     = FIFO_CNT_W'(w_accept) + FIFO_CNT_W'(r_p1_valid);
      w_credit_nx   = w_fifo_cnt_nx + w_infl_nx;
      w_in_ready_nx = w_busy_nx && (w_acc_nx < NUM_PIX_L) &&
                      (w_credit_nx < FIFO_CNT_W'(FIFO_DEPTH));
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state    <= S_IDLE;
         r_addr     <= RGB_BASE;
         r_data     <= '0;
         r_we_n     <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_in_ready <= 1'b0;
         r_acc_cnt  <= '0;
         r_pair_cnt <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_addr     <= w_addr_nx;
         r_data     <= w_data_nx;
         r_we_n     <= w_we_n_nx;
         r_busy     <= w_busy_nx;
         r_done     <= w_done_nx;
         r_in_ready <= w_in_ready_nx;
         r_acc_cnt  <= w_acc_nx;
         r_pair_cnt <= w_pair_nx;
      end
   end

   assign in_ready        = r_in_ready;
   assign SRAM_address    = r_addr;
   assign SRAM_write_data = r_data;
   assign SRAM_we_n       = r_we_n;
   assign busy            = r_busy;
   assign done            = r_done;

endmodule
